// File: rtl/seven_seg_pkg.sv
// Shared definitions for the BCD seven-segment scanner.
// Holds the FSM states and the active-low segment patterns in {g,f,e,d,c,b,a} order.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      s_IDLE  = 2'd0,
      s_GUARD = 2'd1,
      s_DRIVE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_seven_seg_scan_if.sv
// Host-side bundle for the scanner: value load strobe towards the display,
// scan outputs back from it.
interface bcd_seven_seg_scan_if #(
   parameter int unsigned DECIMAL_DIGITS = 4
);
   logic [DECIMAL_DIGITS*4-1:0] bcd;
   logic                        dv;
   logic                        blank_lead;
   logic [6:0]                  segments;
   logic [DECIMAL_DIGITS-1:0]   anodes;
   logic                        frame;

   modport master (output bcd, dv, blank_lead, input segments, anodes, frame);
   modport slave  (input bcd, dv, blank_lead, output segments, anodes, frame);
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational BCD digit to active-low segment decoder; blank overrides the digit.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_Digit,
   input  logic       i_Blank,
   output logic [6:0] o_Segments
);

   always_comb begin
      o_Segments = i_Blank ? SEG_BLANK : seg_lookup(i_Digit);
   end

endmodule

// File: rtl/bcd_seven_seg_scan.sv
// Multiplexed seven-segment scanner with per-slot anti-ghost guard, leading-zero
// blanking and frame-aligned (tear-free) value updates.
module bcd_seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned DECIMAL_DIGITS = 4,
   parameter int unsigned SLOT_CYCLES    = 100000,
   parameter int unsigned GUARD_CYCLES   = 16
) (
   input  logic                        i_Clock,
   input  logic                        i_Reset_n,
   input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
   input  logic                        i_DV,
   input  logic                        i_Blank_Lead,
   output logic [6:0]                  o_Segments,
   output logic [DECIMAL_DIGITS-1:0]   o_Anodes,
   output logic                        o_Frame
);

   localparam int unsigned CW = $clog2(SLOT_CYCLES);
   localparam int unsigned IW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
   localparam int unsigned BW = DECIMAL_DIGITS * 4;

   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DECIMAL_DIGITS - 1);

   state_t                  r_State;
   logic [CW-1:0]           r_Count;
   logic [IW-1:0]           r_Index;
   logic [BW-1:0]           r_Pend_BCD;
   logic                    r_Pend_Blank;
   logic                    r_Pend_Valid;
   logic [BW-1:0]           r_Shown_BCD;
   logic                    r_Shown_Blank;

   logic [DECIMAL_DIGITS:0]   w_Zero_Run;
   logic [3:0]                w_Digit;
   logic                      w_Blank;
   logic [6:0]                w_Seg;
   logic [DECIMAL_DIGITS-1:0] w_Anode_Sel;
   logic                      w_Frame_Start;

   // w_Zero_Run[k]: digit k and every digit above it are zero.
   always_comb begin
      w_Zero_Run                 = '0;
      w_Zero_Run[DECIMAL_DIGITS] = 1'b1;
      for (int unsigned k = DECIMAL_DIGITS; k > 0; k--) begin
         w_Zero_Run[k-1] = w_Zero_Run[k] && (r_Shown_BCD[(k-1)*4 +: 4] == 4'd0);
      end
      w_Digit = '0;
      w_Blank = 1'b0;
      for (int unsigned k = 0; k < DECIMAL_DIGITS; k++) begin
         if (r_Index == IW'(k)) begin
            w_Digit = r_Shown_BCD[k*4 +: 4];
            w_Blank = (k != 0) && r_Shown_Blank && w_Zero_Run[k];
         end
      end
   end

   always_comb begin
      w_Anode_Sel   = ~(DECIMAL_DIGITS'(1) << r_Index);
      w_Frame_Start = ((r_State == s_IDLE) && (r_Pend_Valid || i_DV)) ||
                      ((r_State == s_DRIVE) && (r_Count == SLOT_LAST) && (r_Index == IDX_LAST));
   end

   seven_seg_decode u_decode (
      .i_Digit    (w_Digit),
      .i_Blank    (w_Blank),
      .o_Segments (w_Seg)
   );

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_State       <= s_IDLE;
         r_Count       <= '0;
         r_Index       <= '0;
         r_Pend_BCD    <= '0;
         r_Pend_Blank  <= 1'b0;
         r_Pend_Valid  <= 1'b0;
         r_Shown_BCD   <= '0;
         r_Shown_Blank <= 1'b0;
         o_Anodes      <= '1;
         o_Segments    <= SEG_BLANK;
         o_Frame       <= 1'b0;
      end else begin
         o_Frame <= 1'b0;

         if (i_DV) begin
            r_Pend_BCD   <= i_BCD;
            r_Pend_Blank <= i_Blank_Lead;
            r_Pend_Valid <= 1'b1;
         end

         // Shown value only moves at a frame boundary; a same-cycle strobe bypasses pending.
         if (w_Frame_Start) begin
            if (i_DV) begin
               r_Shown_BCD   <= i_BCD;
               r_Shown_Blank <= i_Blank_Lead;
               r_Pend_Valid  <= 1'b0;
               o_Frame       <= 1'b1;
            end else if (r_Pend_Valid) begin
               r_Shown_BCD   <= r_Pend_BCD;
               r_Shown_Blank <= r_Pend_Blank;
               r_Pend_Valid  <= 1'b0;
               o_Frame       <= 1'b1;
            end
         end

         case (r_State)
            s_IDLE: begin
               o_Anodes   <= '1;
               o_Segments <= SEG_BLANK;
               if (r_Pend_Valid || i_DV) begin
                  r_State <= s_GUARD;
                  r_Index <= '0;
                  r_Count <= '0;
               end
            end
            s_GUARD: begin
               o_Anodes   <= '1;
               o_Segments <= SEG_BLANK;
               r_Count    <= r_Count + 1'b1;
               if (r_Count == GUARD_LAST) begin
                  r_State <= s_DRIVE;
               end
            end
            s_DRIVE: begin
               o_Anodes   <= w_Anode_Sel;
               o_Segments <= w_Seg;
               if (r_Count == SLOT_LAST) begin
                  r_State <= s_GUARD;
                  r_Count <= '0;
                  r_Index <= (r_Index == IDX_LAST) ? '0 : r_Index + 1'b1;
               end else begin
                  r_Count <= r_Count + 1'b1;
               end
            end
            default: begin
               r_State    <= s_IDLE;
               r_Count    <= '0;
               r_Index    <= '0;
               o_Anodes   <= '1;
               o_Segments <= SEG_BLANK;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Directed self-checking bench for bcd_seven_seg_scan with 8-clock slots and 2-clock guards.
module tb_bcd_seven_seg_scan;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned SLOT   = 8;
   localparam int unsigned GUARD  = 2;
   localparam int unsigned FRAME  = DIGITS * SLOT;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   bcd_seven_seg_scan_if #(.DECIMAL_DIGITS(DIGITS)) u_if ();

   bcd_seven_seg_scan #(
      .DECIMAL_DIGITS (DIGITS),
      .SLOT_CYCLES    (SLOT),
      .GUARD_CYCLES   (GUARD)
   ) u_dut (
      .i_Clock      (clk),
      .i_Reset_n    (rst_n),
      .i_BCD        (u_if.bcd),
      .i_DV         (u_if.dv),
      .i_Blank_Lead (u_if.blank_lead),
      .o_Segments   (u_if.segments),
      .o_Anodes     (u_if.anodes),
      .o_Frame      (u_if.frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts at the sample just after a frame-start edge; walks one full frame.
   // inj_tick>0 raises i_DV so it is captured by edge (inj_tick+1) after frame start.
   task automatic check_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input int inj_tick,
                              input logic [15:0] inj_bcd, input logic inj_blank);
      logic [6:0] exp_seg [DIGITS];
      logic [3:0] exp_an;
      int         slot;
      int         pos;
      exp_seg[0] = s0;
      exp_seg[1] = s1;
      exp_seg[2] = s2;
      exp_seg[3] = s3;
      for (int t = 1; t <= int'(FRAME); t++) begin
         if (t == inj_tick) begin
            u_if.bcd        = inj_bcd;
            u_if.blank_lead = inj_blank;
            u_if.dv         = 1'b1;
         end else begin
            u_if.dv = 1'b0;
         end
         tick();
         slot = (t - 1) / int'(SLOT);
         pos  = (t - 1) % int'(SLOT);
         if (pos < int'(GUARD)) begin
            check($sformatf("%s_guard_d%0d", tag, slot), 32'(u_if.anodes), 32'h0000000F);
         end else begin
            exp_an = ~(4'b0001 << slot);
            check($sformatf("%s_anode_d%0d", tag, slot), 32'(u_if.anodes), 32'(exp_an));
            check($sformatf("%s_seg_d%0d", tag, slot), 32'(u_if.segments), 32'(exp_seg[slot]));
         end
         if (t < int'(FRAME)) begin
            check($sformatf("%s_frame_quiet", tag), 32'(u_if.frame), 32'd0);
         end
      end
      u_if.dv = 1'b0;
   endtask

   initial begin
      int bad;
      n_tests         = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      u_if.bcd        = '0;
      u_if.dv         = 1'b0;
      u_if.blank_lead = 1'b0;

      repeat (3) tick();
      check("rst_anodes", 32'(u_if.anodes), 32'h0000000F);
      check("rst_segs", 32'(u_if.segments), 32'(SB));
      check("rst_frame", 32'(u_if.frame), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle_anodes", 32'(u_if.anodes), 32'h0000000F);
      check("idle_segs", 32'(u_if.segments), 32'(SB));

      u_if.bcd = 16'h1234;
      u_if.dv  = 1'b1;
      tick();
      check("t1234_frame", 32'(u_if.frame), 32'd1);
      check_frame("t1234", S1, S2, S3, S4, 0, 16'h0, 1'b0);
      check("t1234_no_refresh", 32'(u_if.frame), 32'd0);

      // New value arrives during the digit-2 slot: must not tear the current frame.
      check_frame("t1234_hold", S1, S2, S3, S4, 18, 16'h5678, 1'b0);
      check("t5678_frame", 32'(u_if.frame), 32'd1);

      check_frame("t5678", S5, S6, S7, S8, 32, 16'h9999, 1'b0);
      check("t9999_bypass_frame", 32'(u_if.frame), 32'd1);

      check_frame("t9999", S9, S9, S9, S9, 32, 16'h0070, 1'b1);
      check("t0070b_frame", 32'(u_if.frame), 32'd1);

      check_frame("t0070_blank", SB, SB, S7, S0, 32, 16'h0070, 1'b0);
      check("t0070_frame", 32'(u_if.frame), 32'd1);

      check_frame("t0070_noblank", S0, S0, S7, S0, 32, 16'h00A0, 1'b1);
      check("t00A0_frame", 32'(u_if.frame), 32'd1);

      check_frame("t00A0_dash", SB, SB, SD, S0, 32, 16'h0000, 1'b1);
      check("t0000_frame", 32'(u_if.frame), 32'd1);

      check_frame("t0000_digit0", SB, SB, SB, S0, 0, 16'h0, 1'b0);
      check("t0000_no_refresh", 32'(u_if.frame), 32'd0);

      repeat (5) tick();
      check("pre_rst_anodes", 32'(u_if.anodes), 32'h0000000E);
      rst_n = 1'b0;
      #1;
      check("async_rst_anodes", 32'(u_if.anodes), 32'h0000000F);
      check("async_rst_segs", 32'(u_if.segments), 32'(SB));
      check("async_rst_frame", 32'(u_if.frame), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (u_if.anodes !== 4'hF || u_if.segments !== SB || u_if.frame !== 1'b0) bad++;
      end
      check("post_rst_idle_bad_cycles", 32'(bad), 32'd0);

      u_if.bcd = 16'h4321;
      u_if.dv  = 1'b1;
      tick();
      check("t4321_frame", 32'(u_if.frame), 32'd1);
      check_frame("t4321", S4, S3, S2, S1, 0, 16'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
